// File: rtl/result_pkg.sv
// result_pkg: shared types and helpers for result_collector.
//   state_t     - collector FSM state
//   ERR_CNT_W   - width of the saturating mismatch counter
//   CHK_W       - width of the running checksum
//   golden_res  - reference function (A+B); the caller truncates to RES_WIDTH
package result_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   localparam int ERR_CNT_W = 16;
   localparam int CHK_W     = 16;

   // Full-width sum; callers cast down to their result width, which gives the
   // mod 2^RES_WIDTH behaviour of the bfm.
   function automatic logic [31:0] golden_res(input logic [31:0] a, input logic [31:0] b);
      return a + b;
   endfunction
endpackage

// File: rtl/result_collector_if.sv
// result_collector_if: operand/result sampling bus plus status and readback.
//   master: harness side (drives start/valid/operands/result/read address)
//   slave : collector side (drives read data and run statistics)
interface result_collector_if #(
   parameter int OP_WIDTH  = 8,
   parameter int RES_WIDTH = 8,
   parameter int NUM       = 100
);
   import result_pkg::*;

   localparam int AW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int CW = $clog2(NUM + 1);

   logic                 start_i;
   logic                 valid_i;
   logic [OP_WIDTH-1:0]  a_i;
   logic [OP_WIDTH-1:0]  b_i;
   logic [RES_WIDTH-1:0] res_i;
   logic [AW-1:0]        rd_addr_i;
   logic [RES_WIDTH-1:0] rd_data_o;
   logic                 busy_o;
   logic                 done_o;
   logic [CW-1:0]        count_o;
   logic [ERR_CNT_W-1:0] err_count_o;
   logic [AW-1:0]        first_err_idx_o;
   logic [CHK_W-1:0]     checksum_o;

   modport master (
      output start_i, valid_i, a_i, b_i, res_i, rd_addr_i,
      input  rd_data_o, busy_o, done_o, count_o, err_count_o, first_err_idx_o, checksum_o
   );

   modport slave (
      input  start_i, valid_i, a_i, b_i, res_i, rd_addr_i,
      output rd_data_o, busy_o, done_o, count_o, err_count_o, first_err_idx_o, checksum_o
   );
endinterface

// File: rtl/result_collector_op_delay_line.sv
// op_delay_line: LATENCY-deep shift register of {valid, a, b}, so each operand
// pair leaves the line on the same edge its bfm result arrives.
//   clk_i/reset_i   - clock, async active-high reset (all stages invalid)
//   flush_i         - synchronous: every stage loaded invalid this edge
//   vld_i/a_i/b_i   - stage 0 input
//   vld_o/a_o/b_o   - last stage output
module op_delay_line #(
   parameter int OP_WIDTH = 8,
   parameter int LATENCY  = 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                flush_i,
   input  logic                vld_i,
   input  logic [OP_WIDTH-1:0] a_i,
   input  logic [OP_WIDTH-1:0] b_i,
   output logic                vld_o,
   output logic [OP_WIDTH-1:0] a_o,
   output logic [OP_WIDTH-1:0] b_o
);
   logic [LATENCY-1:0]               vld_pipe_q, vld_pipe_d;
   logic [LATENCY-1:0][OP_WIDTH-1:0] a_pipe_q, a_pipe_d;
   logic [LATENCY-1:0][OP_WIDTH-1:0] b_pipe_q, b_pipe_d;

   always_comb begin
      vld_pipe_d    = '0;
      a_pipe_d      = '0;
      b_pipe_d      = '0;
      vld_pipe_d[0] = vld_i & ~flush_i;
      a_pipe_d[0]   = a_i;
      b_pipe_d[0]   = b_i;
      for (int i = 1; i < LATENCY; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1] & ~flush_i;
         a_pipe_d[i]   = a_pipe_q[i-1];
         b_pipe_d[i]   = b_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         vld_pipe_q <= '0;
         a_pipe_q   <= '0;
         b_pipe_q   <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         a_pipe_q   <= a_pipe_d;
         b_pipe_q   <= b_pipe_d;
      end
   end

   assign vld_o = vld_pipe_q[LATENCY-1];
   assign a_o   = a_pipe_q[LATENCY-1];
   assign b_o   = b_pipe_q[LATENCY-1];
endmodule

// File: rtl/result_collector.sv
// result_collector: samples operand pairs and the bfm result LATENCY edges
// later, buffers NUM results, checks them against (A+B) mod 2^RES_WIDTH and
// keeps a checksum and mismatch statistics for readback.
//   clk_i/reset_i - clock, async active-high reset
//   bus (slave)   - start/valid/operands/result in; registered read port,
//                   busy/done flags, count, err_count, first_err_idx, checksum out
module result_collector
   import result_pkg::*;
#(
   parameter int OP_WIDTH  = 8,
   parameter int RES_WIDTH = 8,
   parameter int NUM       = 100,
   parameter int LATENCY   = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   result_collector_if.slave  bus
);
   localparam int AW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int CW = $clog2(NUM + 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic [AW-1:0]        first_err_q, first_err_d;
   logic [CHK_W-1:0]     chk_q, chk_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [RES_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [RES_WIDTH-1:0] buf_q [NUM];

   logic                 dl_vld, dl_load, flush, cap, last_cap;
   logic [OP_WIDTH-1:0]  dl_a, dl_b;
   logic [RES_WIDTH-1:0] exp_res;

   // Pairs only enter the line while collecting; anything sent in IDLE/DONE
   // never reaches the capture point.
   assign dl_load = bus.valid_i & (state_q == COLLECT);

   op_delay_line #(
      .OP_WIDTH (OP_WIDTH),
      .LATENCY  (LATENCY)
   ) u_dly (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush),
      .vld_i   (dl_load),
      .a_i     (bus.a_i),
      .b_i     (bus.b_i),
      .vld_o   (dl_vld),
      .a_o     (dl_a),
      .b_o     (dl_b)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      err_d       = err_q;
      first_err_d = first_err_q;
      chk_d       = chk_q;
      exp_res     = RES_WIDTH'(golden_res(32'(dl_a), 32'(dl_b)));
      // start wins over a coinciding capture
      cap         = dl_vld && (state_q == COLLECT) && !bus.start_i;
      last_cap    = cap && (count_q == CW'(NUM - 1));
      // Leftover pairs are dropped on restart and when the run completes
      flush       = bus.start_i || last_cap;

      if (bus.start_i) begin
         state_d     = COLLECT;
         count_d     = '0;
         err_d       = '0;
         first_err_d = '0;
         chk_d       = '0;
      end else if (cap) begin
         count_d = count_q + CW'(1);
         chk_d   = chk_q + CHK_W'(bus.res_i);
         if (bus.res_i != exp_res) begin
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
            if (err_q == '0) first_err_d = count_q[AW-1:0];
         end
         if (last_cap) state_d = DONE;
      end

      busy_d    = (state_d == COLLECT);
      done_d    = (state_d == DONE);
      rd_data_d = '0;
      if (32'(bus.rd_addr_i) < NUM) rd_data_d = buf_q[bus.rd_addr_i];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         count_q     <= '0;
         err_q       <= '0;
         first_err_q <= '0;
         chk_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         err_q       <= err_d;
         first_err_q <= first_err_d;
         chk_q       <= chk_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Result buffer holds its contents across restarts, so no reset
   always_ff @(posedge clk_i) begin
      if (cap) buf_q[count_q[AW-1:0]] <= bus.res_i;
   end

   assign bus.rd_data_o       = rd_data_q;
   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
   assign bus.count_o         = count_q;
   assign bus.err_count_o     = err_q;
   assign bus.first_err_idx_o = first_err_q;
   assign bus.checksum_o      = chk_q;
endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;
   import result_pkg::*;

   logic clk = 1'b0;
   logic rst1, rst3;
   always #5 clk = ~clk;

   result_collector_if #(.OP_WIDTH(8), .RES_WIDTH(8), .NUM(4)) if1 ();
   result_collector_if #(.OP_WIDTH(8), .RES_WIDTH(8), .NUM(4)) if3 ();

   result_collector #(.OP_WIDTH(8), .RES_WIDTH(8), .NUM(4), .LATENCY(1)) dut1 (
      .clk_i(clk), .reset_i(rst1), .bus(if1.slave));
   result_collector #(.OP_WIDTH(8), .RES_WIDTH(8), .NUM(4), .LATENCY(3)) dut3 (
      .clk_i(clk), .reset_i(rst3), .bus(if3.slave));

   typedef struct {
      logic [7:0] a, b, res;
      int cnt, err, chk;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;

   vec_t clean_v [4];
   vec_t errs_v  [4];
   vec_t lat3_v  [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive1(input bit s, input bit v, input logic [7:0] a, b, r);
      if1.start_i = s; if1.valid_i = v; if1.a_i = a; if1.b_i = b; if1.res_i = r;
   endtask

   task automatic drive3(input bit s, input bit v, input logic [7:0] a, b, r);
      if3.start_i = s; if3.valid_i = v; if3.a_i = a; if3.b_i = b; if3.res_i = r;
   endtask

   // Full NUM=4 run on the LATENCY=1 instance driven from a table
   task automatic run4(input vec_t rows [4], input int exp_first, input string tag);
      drive1(1, 0, 0, 0, 0);
      @(negedge clk);
      check({tag, " start busy"}, 32'(if1.busy_o), 1);
      check({tag, " start done"}, 32'(if1.done_o), 0);
      check({tag, " start count"}, 32'(if1.count_o), 0);
      check({tag, " start err"}, 32'(if1.err_count_o), 0);
      check({tag, " start chk"}, 32'(if1.checksum_o), 0);
      for (int i = 0; i <= 4; i++) begin
         logic [7:0] a, b, r;
         a = 0; b = 0; r = 0;
         if (i < 4) begin a = rows[i].a; b = rows[i].b; end
         if (i > 0) r = rows[i-1].res;
         drive1(0, i < 4, a, b, r);
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("%s count[%0d]", tag, i-1), 32'(if1.count_o), rows[i-1].cnt);
            check($sformatf("%s err[%0d]", tag, i-1), 32'(if1.err_count_o), rows[i-1].err);
            check($sformatf("%s chk[%0d]", tag, i-1), 32'(if1.checksum_o), rows[i-1].chk);
            check($sformatf("%s done[%0d]", tag, i-1), 32'(if1.done_o), (i == 4) ? 1 : 0);
            check($sformatf("%s busy[%0d]", tag, i-1), 32'(if1.busy_o), (i < 4) ? 1 : 0);
         end
      end
      if (exp_first >= 0) check({tag, " first_err"}, 32'(if1.first_err_idx_o), exp_first);
      drive1(0, 0, 0, 0, 0);
      for (int j = 0; j < 4; j++) begin
         if1.rd_addr_i = 2'(j);
         @(negedge clk);
         check($sformatf("%s rd[%0d]", tag, j), 32'(if1.rd_data_o), 32'(rows[j].res));
      end
      // pairs after completion are ignored
      for (int j = 0; j < 3; j++) begin
         drive1(0, 1, 9, 9, 18);
         @(negedge clk);
      end
      drive1(0, 0, 0, 0, 0);
      @(negedge clk);
      check({tag, " post count"}, 32'(if1.count_o), 4);
      check({tag, " post done"}, 32'(if1.done_o), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clean_v[0] = '{1,   2,  3, 1, 0,  3};
      clean_v[1] = '{3,   4,  7, 2, 0, 10};
      clean_v[2] = '{250, 10, 4, 3, 0, 14};
      clean_v[3] = '{0,   0,  0, 4, 0, 14};
      errs_v[0]  = '{1,   2,  3, 1, 0,  3};
      errs_v[1]  = '{3,   4,  8, 2, 1, 11};
      errs_v[2]  = '{250, 10, 5, 3, 2, 16};
      errs_v[3]  = '{0,   0,  0, 4, 2, 16};
      // LATENCY=3, continuous valid: res at edge k is the sum sent at edge k-3
      lat3_v[0]  = '{10,  20,  0, 0, 0,  0};
      lat3_v[1]  = '{100, 200, 0, 0, 0,  0};
      lat3_v[2]  = '{255, 1,   0, 0, 0,  0};
      lat3_v[3]  = '{7,   8,  30, 1, 0, 30};
      lat3_v[4]  = '{1,   1,  44, 2, 0, 74};
      lat3_v[5]  = '{2,   2,   0, 3, 0, 74};
      lat3_v[6]  = '{3,   3,  15, 4, 0, 89};
      lat3_v[7]  = '{4,   4,   2, 4, 0, 89};
      lat3_v[8]  = '{5,   5,   4, 4, 0, 89};
      lat3_v[9]  = '{6,   6,   6, 4, 0, 89};

      drive1(0, 0, 0, 0, 0); drive3(0, 0, 0, 0, 0);
      if1.rd_addr_i = 0; if3.rd_addr_i = 0;
      rst1 = 1; rst3 = 1;
      repeat (2) @(negedge clk);
      rst1 = 0; rst3 = 0;

      // Reset state, then valid without start is ignored
      check("rst busy", 32'(if1.busy_o), 0);
      check("rst done", 32'(if1.done_o), 0);
      check("rst count", 32'(if1.count_o), 0);
      check("rst err", 32'(if1.err_count_o), 0);
      check("rst first", 32'(if1.first_err_idx_o), 0);
      check("rst chk", 32'(if1.checksum_o), 0);
      check("rst rd", 32'(if1.rd_data_o), 0);
      for (int i = 0; i < 3; i++) begin
         drive1(0, 1, 8'(i + 1), 1, 8'(i + 2));
         drive3(0, 1, 8'(i + 1), 1, 8'(i + 2));
         @(negedge clk);
      end
      drive1(0, 0, 0, 0, 0); drive3(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("idle count1", 32'(if1.count_o), 0);
      check("idle chk1", 32'(if1.checksum_o), 0);
      check("idle busy1", 32'(if1.busy_o), 0);
      check("idle done1", 32'(if1.done_o), 0);
      check("idle count3", 32'(if3.count_o), 0);
      check("idle busy3", 32'(if3.busy_o), 0);

      run4(clean_v, -1, "clean");
      run4(errs_v, 1, "errs");   // restarted from DONE

      // start colliding with a capture mid-run
      drive1(1, 0, 0, 0, 0); @(negedge clk);
      drive1(0, 1, 1, 2, 0); @(negedge clk);
      drive1(0, 1, 5, 5, 3); @(negedge clk);
      check("coll pre count", 32'(if1.count_o), 1);
      check("coll pre chk", 32'(if1.checksum_o), 3);
      drive1(1, 1, 7, 7, 10); @(negedge clk);
      check("coll count", 32'(if1.count_o), 0);
      check("coll chk", 32'(if1.checksum_o), 0);
      check("coll err", 32'(if1.err_count_o), 0);
      check("coll busy", 32'(if1.busy_o), 1);
      drive1(0, 1, 2, 2, 14); @(negedge clk);
      check("coll flushed", 32'(if1.count_o), 0);
      drive1(0, 0, 0, 0, 5); @(negedge clk);
      check("coll next count", 32'(if1.count_o), 1);
      check("coll next chk", 32'(if1.checksum_o), 5);
      check("coll next err", 32'(if1.err_count_o), 1);
      check("coll next first", 32'(if1.first_err_idx_o), 0);

      // asynchronous reset between edges
      #2 rst1 = 1;
      #1;
      check("arst count", 32'(if1.count_o), 0);
      check("arst err", 32'(if1.err_count_o), 0);
      check("arst chk", 32'(if1.checksum_o), 0);
      check("arst busy", 32'(if1.busy_o), 0);
      check("arst done", 32'(if1.done_o), 0);
      check("arst rd", 32'(if1.rd_data_o), 0);
      @(negedge clk);
      rst1 = 0;
      for (int i = 0; i < 3; i++) begin
         drive1(0, 1, 1, 1, 2);
         @(negedge clk);
      end
      drive1(0, 0, 0, 0, 0);
      @(negedge clk);
      check("arst after count", 32'(if1.count_o), 0);
      check("arst after busy", 32'(if1.busy_o), 0);

      // LATENCY=3 run with continuous valid
      drive3(1, 0, 0, 0, 0); @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         drive3(0, 1, lat3_v[k].a, lat3_v[k].b, lat3_v[k].res);
         @(negedge clk);
         check($sformatf("lat3 count[%0d]", k), 32'(if3.count_o), lat3_v[k].cnt);
         check($sformatf("lat3 chk[%0d]", k), 32'(if3.checksum_o), lat3_v[k].chk);
         check($sformatf("lat3 err[%0d]", k), 32'(if3.err_count_o), lat3_v[k].err);
      end
      drive3(0, 0, 0, 0, 0);
      check("lat3 done", 32'(if3.done_o), 1);
      check("lat3 busy", 32'(if3.busy_o), 0);
      for (int j = 0; j < 4; j++) begin
         if3.rd_addr_i = 2'(j);
         @(negedge clk);
         check($sformatf("lat3 rd[%0d]", j), 32'(if3.rd_data_o), 32'(lat3_v[j+3].res));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/result_collector.md
# result_collector

Receive-side companion to the operand driver in the cocotb test harness. Samples each operand pair (A, B) presented to the `bfm` together with the `res_o` it produces `LATENCY` cycles later. Stores each result in an internal buffer, checks it against the golden function `(A+B) mod 256`, and keeps a running checksum and error statistics. Sits beside `bfm` inside `wrapper`, so a Python test can read back a whole `NUM`-item run from one module.

## Interface
Parameters:
- `OP_WIDTH`, 8, width of each operand
- `RES_WIDTH`, 8, width of the result
- `NUM`, 100, items per run; also buffer depth
- `LATENCY`, 1, cycles from operand edge to result edge in `bfm` (≥1)

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; asynchronous, active-high
- `start_i`  in  1  arm/restart a run (single-cycle pulse)
- `valid_i`  in  1  `a_i`/`b_i` carry an operand pair this edge
- `a_i`  in  `OP_WIDTH`  operand A, same signal as driven to `bfm`
- `b_i`  in  `OP_WIDTH`  operand B
- `res_i`  in  `RES_WIDTH`  `bfm` result
- `rd_addr_i`  in  `$clog2(NUM)`  buffer read address
- `rd_data_o`  out  `RES_WIDTH`  buffer read data
- `busy_o`  out  1  run in progress
- `done_o`  out  1  `NUM` results captured
- `count_o`  out  `$clog2(NUM+1)`  results captured this run
- `err_count_o`  out  16  mismatches, saturating at 0xFFFF
- `first_err_idx_o`  out  `$clog2(NUM)`  index of first mismatch; valid only while `err_count_o` ≠ 0
- `checksum_o`  out  16  sum of captured results, mod 2^16

## Operation
- FSM states: IDLE, COLLECT, DONE.
  - IDLE → COLLECT on `start_i`.
  - COLLECT → DONE on the capture that makes the count equal `NUM`.
  - DONE → COLLECT on `start_i`.
- On `start_i` (any state), the block does the following:
  - clears `count`, `err_count`, `first_err_idx` and `checksum`;
  - flushes the delay line;
  - does not clear the buffer contents.
- Delay line: `LATENCY` stages of {valid, a, b}. Stage 0 loads `valid_i & (state==COLLECT)`.
- Capture: happens when the last delay stage is valid and the state is COLLECT. On each capture:
  - write `res_i` to `buf[count]`;
  - increment `count`;
  - add `res_i` zero-extended to `checksum`;
  - compute `exp = (a_d + b_d)[RES_WIDTH-1:0]`;
  - if `res_i ≠ exp`, increment `err_count` (saturating);
  - if that is the first error, latch `count` into `first_err_idx`.
- `valid_i` in IDLE or DONE is ignored. Pairs already in the delay line when the state reaches DONE are discarded.
- `start_i` coinciding with a capture: `start_i` wins. The capture is dropped and all counters are cleared.
- Read port works in any state. It is registered with 1-cycle latency. `rd_addr_i ≥ NUM` returns 0.

## Timing
- Reset values of all outputs:
  - `busy_o`, `done_o`, `count_o`, `err_count_o`, `first_err_idx_o`, `checksum_o`, `rd_data_o` all reset to 0;
  - state resets to IDLE;
  - the delay line resets to all invalid.
- Flags: `busy_o` = (state==COLLECT); `done_o` = (state==DONE). Both are registered.
- Pair/result alignment: a pair with `valid_i` at edge t pairs with `res_i` sampled at edge t+`LATENCY`.
- `count_o`, `err_count_o`, `checksum_o` and `first_err_idx_o` update on the capture edge. They are visible in the following cycle.
- The `NUM`-th capture at edge t has these effects:
  - `done_o` and `busy_o`=0 are visible from t+1;
  - a `valid_i` at edge t+1 or later is ignored.
- `start_i` at edge t: `busy_o` is high from t+1. The earliest capturable pair is `valid_i` at edge t+1.
- Back-to-back `valid_i` every cycle is supported. There are no stalls.
- Asserting `reset_i` mid-run clears everything immediately, asynchronously. `start_i` is required after release.

## Structure
- Package `result_pkg`:
  - FSM state enum `state_t` {IDLE, COLLECT, DONE};
  - `ERR_CNT_W`=16 and `CHK_W`=16;
  - function `golden_res(a, b)` returning the truncated sum.
- Sub-module `op_delay_line`: a `LATENCY`-deep shift register of {valid, a, b} with asynchronous reset and a synchronous flush input.
- Buffer: a register array `NUM`×`RES_WIDTH` with no reset, inferred in the top module.

## Test plan
- Reset then idle: `valid_i` pulses with no `start_i` give `count_o`=0, `done_o`=0 and all outputs 0.
- Clean run, `NUM`=4, `LATENCY`=1:
  - stimulus: `start_i`; pairs (1,2), (3,4), (250,10), (0,0); `res_i` = correct sums;
  - required: `done_o` set one cycle after the 4th capture; `count_o`=4; `err_count_o`=0; `checksum_o`=3+7+4+0=14; readback shows `buf` = {3,7,4,0}.
- Injected errors: same run but with `res_i`=8 for item 1 and `res_i`=5 for item 2. Required: `err_count_o`=2, `first_err_idx_o`=1.
- `LATENCY`=3 with continuous `valid_i`: every capture pairs with the operands sent 3 edges earlier. Extra pairs after the 4th capture leave `count_o`=4.
- `start_i` asserted in DONE and on a capture edge mid-run: counters clear, and the colliding capture is not counted.
- `reset_i` asserted asynchronously mid-run, between edges: outputs are 0 immediately and state is IDLE. A following `valid_i` is ignored until `start_i`.
